alu_seq_controller: RTL and testbench
=====================================

// Module: alu_seq_controller
// PURPOSE
//  Registered, handshaked successor of the ALU function decoder. Maps a 6-bit op code to the
//  ALU control word (aluc) for single-cycle ops. Adds iterative MULTU/DIVU sequencing
//  (shift-add / restoring divide) producing HI/LO. Sits between decode and EX; in_ready stalls issue.
// PARAMETERS
//  WIDTH   32  operand / HI / LO width (>=4, even)
//  ALUC_W  5   aluc width (>=5; upper bits zero-extended)
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        op/a/b valid this cycle
//  in_ready   out  1        unit can accept; transfer = in_valid & in_ready
//  op         in   6        function / op code
//  a, b       in   WIDTH    operands (used by MULTU/DIVU only)
//  out_valid  out  1        one-cycle pulse: result fields valid
//  aluc       out  ALUC_W   decoded ALU control word
//  illegal    out  1        op not in table (valid with out_valid)
//  div0       out  1        DIVU with b==0 (valid with out_valid)
//  hi, lo     out  WIDTH    MULTU: {hi,lo}=a*b; DIVU: lo=a/b, hi=a%b
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, aluc=0, illegal=0, div0=0, hi=0, lo=0, FSM=IDLE, count=0.
//  Decode table (op -> aluc): 100000->00010 100001->00000 100010->00011 100011->00001
//   100100->00100 100101->00101 100110->00110 100111->00111 101010->01011 101011->01010
//   000000,000100->01111 000010,000110->01101 000011,000111->01100 001111->01000
//   011100->10000 011101->10001 011001(MULTU)->11000 011011(DIVU)->11001.
//  Other op: aluc=0, illegal=1. No latch of stale aluc; every accepted op drives aluc.
//  FSM IDLE: in_ready=1. Accept single-cycle/illegal op -> next cycle out_valid=1, aluc/illegal
//   registered, hi/lo unchanged; stays IDLE (back-to-back one op per cycle).
//  Accept MULTU -> MUL, DIVU with b!=0 -> DIV: latch a,b, count=0, in_ready=0.
//  Accept DIVU with b==0 -> next cycle out_valid=1, div0=1, lo=all ones, hi=a; stays IDLE.
//  MUL/DIV: one iteration per cycle, count increments; after WIDTH iterations -> DONE.
//   Latency accept->out_valid = WIDTH+1 cycles; in_ready low for exactly WIDTH+1 cycles.
//  DONE: out_valid=1, hi/lo final, aluc=op code word, illegal=0, div0=0; -> IDLE,
//   in_ready=1 same cycle (next op may be accepted while DONE pulses).
//  out_valid is never high for two cycles for one op; no backpressure on output.
//  hi/lo hold last MULTU/DIVU result until next one completes (readable any time).
//  in_valid while in_ready=0: ignored, no state change (issuer must hold).
//  Arithmetic unsigned, full 2*WIDTH product, no overflow flag; iteration counter width clog2(WIDTH)+1.
//  rst mid-iteration: abort, all outputs to reset values next cycle, no out_valid.
//  rst has priority over in_valid in the same cycle.
// TESTING
//  1. Reset 3 cycles -> in_ready=1, out_valid=0, aluc=0, hi=lo=0.
//  2. Back-to-back ops 100000,101011,001111,011101 -> out_valid each following cycle, aluc
//     00010,01010,01000,10001.
//  3. op=111111 -> out_valid, illegal=1, aluc=0; next op 100100 -> illegal=0, aluc=00100.
//  4. MULTU a=32'hFFFF_FFFF b=2 -> in_ready low 33 cycles, then hi=1, lo=32'hFFFF_FFFE, aluc=11000.
//  5. DIVU a=100 b=7 -> after 33 cycles lo=14, hi=2; DIVU a=5 b=0 -> 1 cycle, div0=1,
//     lo=32'hFFFF_FFFF, hi=5.
//  6. rst at iteration 10 of DIVU -> no out_valid, in_ready=1 next cycle, hi=lo=0;
//     in_valid held during busy ignored.

Source files
------------

// File: rtl/alu_seq_controller.sv
// alu_seq_controller: handshaked op->aluc decoder with iterative MULTU/DIVU; ports clk rst in_valid/in_ready op a b -> out_valid aluc illegal div0 hi lo
module alu_seq_controller #(
  parameter int WIDTH  = 32,
  parameter int ALUC_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal,
  output logic              div0,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] opd, rh, rl, nh, nl;
  logic [WIDTH:0] s, t, d;
  logic [4:0] code;
  logic bad, acc, is_mul, is_div, busy, last;
  always_comb begin
    bad = 1'b0;
    code = 5'b00000;
    case (op)
      6'b100000: code = 5'b00010;
      6'b100001: code = 5'b00000;
      6'b100010: code = 5'b00011;
      6'b100011: code = 5'b00001;
      6'b100100: code = 5'b00100;
      6'b100101: code = 5'b00101;
      6'b100110: code = 5'b00110;
      6'b100111: code = 5'b00111;
      6'b101010: code = 5'b01011;
      6'b101011: code = 5'b01010;
      6'b000000, 6'b000100: code = 5'b01111;
      6'b000010, 6'b000110: code = 5'b01101;
      6'b000011, 6'b000111: code = 5'b01100;
      6'b001111: code = 5'b01000;
      6'b011100: code = 5'b10000;
      6'b011101: code = 5'b10001;
      6'b011001: code = 5'b11000;
      6'b011011: code = 5'b11001;
      default:   bad = 1'b1;
    endcase
  end
  // MUL keeps {rh,rl} as partial product / shifting multiplier; DIV keeps rh as
  // remainder and rl as dividend shifting out while quotient bits shift in.
  // An extra cycle after the last iteration copies rh/rl to hi/lo.
  always_comb begin
    busy = (state == MUL) || (state == DIV);
    in_ready = !busy;
    acc = in_valid && in_ready;
    is_mul = op == 6'b011001;
    is_div = op == 6'b011011;
    last = count == CW'(WIDTH);
    s = {1'b0, rh} + (rl[0] ? {1'b0, opd} : '0);
    t = {rh, rl[WIDTH-1]};
    d = t - {1'b0, opd};
    nh = (state == MUL) ? s[WIDTH:1] : (d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0]);
    nl = (state == MUL) ? {s[0], rl[WIDTH-1:1]} : {rl[WIDTH-2:0], !d[WIDTH]};
    state_n = busy ? (last ? DONE : state) : !acc ? IDLE : is_mul ? MUL :
              (is_div && b != '0) ? DIV : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      opd <= '0;
      rh <= '0;
      rl <= '0;
      out_valid <= 1'b0;
      aluc <= '0;
      illegal <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      out_valid <= 1'b0;
      if (busy) begin
        if (last) begin
          out_valid <= 1'b1;
          hi <= rh;
          lo <= rl;
        end else begin
          count <= count + CW'(1);
          rh <= nh;
          rl <= nl;
        end
      end else if (acc) begin
        aluc <= ALUC_W'(code);
        illegal <= bad;
        div0 <= is_div && b == '0;
        out_valid <= state_n == IDLE;
        if (is_div && b == '0) begin
          hi <= a;
          lo <= '1;
        end
        opd <= is_mul ? a : b;
        rh <= '0;
        rl <= is_mul ? b : a;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_controller.sv
// tb_alu_seq_controller: scoreboard bench with reference model for alu_seq_controller
module tb_alu_seq_controller;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, illegal, div0;
  logic [5:0] op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic [4:0] aluc;
  int total = 0, bad = 0;
  typedef struct {logic [4:0] aluc; logic ill; logic dz; logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t q[$];
  logic [31:0] mhi = 0, mlo = 0;
  alu_seq_controller #(.WIDTH(32), .ALUC_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .aluc(aluc), .illegal(illegal), .div0(div0), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [5:0] ref_dec(input logic [5:0] o);
    case (o)
      6'b100000: return 6'b000010;
      6'b100001: return 6'b000000;
      6'b100010: return 6'b000011;
      6'b100011: return 6'b000001;
      6'b100100: return 6'b000100;
      6'b100101: return 6'b000101;
      6'b100110: return 6'b000110;
      6'b100111: return 6'b000111;
      6'b101010: return 6'b001011;
      6'b101011: return 6'b001010;
      6'b000000, 6'b000100: return 6'b001111;
      6'b000010, 6'b000110: return 6'b001101;
      6'b000011, 6'b000111: return 6'b001100;
      6'b001111: return 6'b001000;
      6'b011100: return 6'b010000;
      6'b011101: return 6'b010001;
      6'b011001: return 6'b011000;
      6'b011011: return 6'b011001;
      default:   return 6'b100000;
    endcase
  endfunction
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("aluc", aluc, e.aluc);
        chk("illegal", illegal, e.ill);
        chk("div0", div0, e.dz);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
      end
    end
  end
  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [5:0] dec;
    bit lng;
    op = o; a = x; b = y; in_valid = 1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    dec = ref_dec(o);
    lng = (o == 6'b011001) || (o == 6'b011011 && y != 0);
    if (o == 6'b011001) {mhi, mlo} = 64'(x) * 64'(y);
    else if (o == 6'b011011 && y != 0) begin mlo = x / y; mhi = x % y; end
    else if (o == 6'b011011) begin mhi = x; mlo = '1; end
    q.push_back('{dec[4:0], dec[5], o == 6'b011011 && y == 0, mhi, mlo});
    @(posedge clk); #1;
    in_valid = 0;
    if (lng) begin
      n = 0;
      while (!in_ready && n < 100) begin
        in_valid = 1; op = 6'($urandom); a = $urandom; b = $urandom;
        @(posedge clk); #1; n++;
      end
      in_valid = 0;
      chk("busy_len", n, 33);
      chk("done_valid", out_valid, 1);
    end else chk("one_cycle_valid", out_valid, 1);
  endtask
  initial begin
    logic [5:0] ops [0:7];
    ops[0] = 6'b100000; ops[1] = 6'b101011; ops[2] = 6'b001111; ops[3] = 6'b011101;
    ops[4] = 6'b000110; ops[5] = 6'b100111; ops[6] = 6'b000011; ops[7] = 6'b011100;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aluc", aluc, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    for (int i = 0; i < 4; i++) issue(ops[i], 0, 0);
    issue(6'b111111, 0, 0);
    issue(6'b100100, 0, 0);
    issue(6'b011001, 32'hFFFF_FFFF, 2);
    issue(6'b011011, 100, 7);
    issue(6'b011011, 5, 0);
    issue(6'b100001, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 5) issue(6'($urandom), $urandom, $urandom);
      else if (k < 7) issue(ops[$urandom_range(0, 7)], 0, 0);
      else if (k == 7) issue(6'b011001, $urandom, $urandom);
      else issue(6'b011011, $urandom, (k == 9) ? 32'($urandom_range(0, 3)) : $urandom);
    end
    repeat (2) @(posedge clk);
    op = 6'b011011; a = 100; b = 7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 1; op = 6'b100000;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    mhi = 0; mlo = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_aluc", aluc, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (40) @(posedge clk);
    #1;
    issue(6'b100010, 0, 0);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
